// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 encodings, FSM state type and request legality check for the data-memory initiator
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE} mau_state_t;

    // Stores only exist as B/H/W; loads additionally allow BU/HU
    function automatic logic mem_req_err(input logic write, input logic [2:0] funct3, input logic [1:0] offset);
        logic illegal;
        logic misaligned;
        illegal    = write ? (funct3 > F3_W) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        misaligned = ((funct3 == F3_H || funct3 == F3_HU) && offset[0]) || (funct3 == F3_W && offset != 2'b00);
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: little-endian lane extraction with sign/zero extension for loads,
// and sub-word merge into the current RAM word for read-modify-write stores
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] mask;
    logic [31:0] lane_data;

    assign lane_byte = word[{offset, 3'b000} +: 8];
    assign lane_half = offset[1] ? word[31:16] : word[15:0];

    assign load_data = funct3 == F3_B  ? {{24{lane_byte[7]}}, lane_byte} :
                       funct3 == F3_BU ? {24'h0, lane_byte} :
                       funct3 == F3_H  ? {{16{lane_half[15]}}, lane_half} :
                       funct3 == F3_HU ? {16'h0, lane_half} : word;

    // Replicating the store lane lets the mask alone pick its position
    assign mask      = funct3 == F3_B ? 32'h0000_00FF << {offset, 3'b000} : 32'h0000_FFFF << {offset[1], 4'b0000};
    assign lane_data = funct3 == F3_B ? {4{wdata[7:0]}} : {2{wdata[15:0]}};
    assign merged    = (funct3 == F3_B || funct3 == F3_H) ? (word & ~mask) | (lane_data & mask) : wdata;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator turning byte-addressed RV32I loads/stores into
// word-wide RAM accesses, using read-modify-write for SB/SH
module mem_access_unit
    import mem_pkg::*;
#(
    parameter  int ADDRESS_SIZE = 1024,
    localparam int A_S          = $clog2(ADDRESS_SIZE)
)(
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           REQ_VALID,
    output logic           REQ_READY,
    input  logic           REQ_WRITE,
    input  logic [2:0]     REQ_FUNCT3,
    input  logic [31:0]    REQ_ADDR,
    input  logic [31:0]    REQ_WDATA,
    output logic           RESP_VALID,
    output logic           RESP_ERR,
    output logic [31:0]    LOAD_DATA,
    output logic [A_S-1:0] RAM_ADDRESS,
    output logic           RAM_MEM_WRITE,
    output logic [31:0]    RAM_WRITE_DATA,
    input  logic [31:0]    RAM_READ_DATA
);

    mau_state_t     state;
    logic [A_S+1:0] addr_q;
    logic [2:0]     funct3_q;
    logic [31:0]    wdata_q;
    logic [31:0]    merged_q;
    logic           write_q;
    logic [31:0]    lane_load;
    logic [31:0]    lane_merged;
    logic           unused_addr;

    // Upper address bits are dropped so accesses wrap modulo the RAM size
    assign unused_addr = ^REQ_ADDR[31:A_S+2];

    byte_lane_unit u_lane (
        .funct3    (funct3_q),
        .offset    (addr_q[1:0]),
        .word      (RAM_READ_DATA),
        .wdata     (wdata_q),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    assign REQ_READY      = state == IDLE;
    assign RAM_ADDRESS    = addr_q[A_S+1:2];
    assign RAM_MEM_WRITE  = RST_N & (state == WRITE | (state == ACCESS & write_q & funct3_q == F3_W));
    assign RAM_WRITE_DATA = state == WRITE ? merged_q : wdata_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            wdata_q    <= '0;
            merged_q   <= '0;
            write_q    <= 1'b0;
            RESP_VALID <= 1'b0;
            RESP_ERR   <= 1'b0;
            LOAD_DATA  <= '0;
        end else begin
            RESP_VALID <= 1'b0;
            RESP_ERR   <= 1'b0;
            case (state)
                IDLE: if (REQ_VALID) begin
                    addr_q   <= REQ_ADDR[A_S+1:0];
                    funct3_q <= REQ_FUNCT3;
                    wdata_q  <= REQ_WDATA;
                    write_q  <= REQ_WRITE;
                    if (mem_req_err(REQ_WRITE, REQ_FUNCT3, REQ_ADDR[1:0])) begin
                        RESP_VALID <= 1'b1;
                        RESP_ERR   <= 1'b1;
                    end else begin
                        state <= ACCESS;
                    end
                end
                ACCESS: if (write_q && funct3_q != F3_W) begin
                    merged_q <= lane_merged;
                    state    <= WRITE;
                end else begin
                    LOAD_DATA  <= write_q ? LOAD_DATA : lane_load;
                    RESP_VALID <= 1'b1;
                    state      <= IDLE;
                end
                WRITE: begin
                    RESP_VALID <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed literal scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the unit and a shadow copy of the RAM
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WRITE = 1'b0;
    logic [2:0]  REQ_FUNCT3 = 3'b0;
    logic [31:0] REQ_ADDR = 32'h0;
    logic [31:0] REQ_WDATA = 32'h0;
    logic        RESP_VALID;
    logic        RESP_ERR;
    logic [31:0] LOAD_DATA;
    logic [9:0]  RAM_ADDRESS;
    logic        RAM_MEM_WRITE;
    logic [31:0] RAM_WRITE_DATA;
    logic [31:0] RAM_READ_DATA;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_access_unit #(.ADDRESS_SIZE(1024)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .REQ_VALID      (REQ_VALID),
        .REQ_READY      (REQ_READY),
        .REQ_WRITE      (REQ_WRITE),
        .REQ_FUNCT3     (REQ_FUNCT3),
        .REQ_ADDR       (REQ_ADDR),
        .REQ_WDATA      (REQ_WDATA),
        .RESP_VALID     (RESP_VALID),
        .RESP_ERR       (RESP_ERR),
        .LOAD_DATA      (LOAD_DATA),
        .RAM_ADDRESS    (RAM_ADDRESS),
        .RAM_MEM_WRITE  (RAM_MEM_WRITE),
        .RAM_WRITE_DATA (RAM_WRITE_DATA),
        .RAM_READ_DATA  (RAM_READ_DATA)
    );

    // RAM attached to the DUT: sync write, async read
    logic [31:0] dmem [1024] = '{default: 32'h0};
    assign RAM_READ_DATA = dmem[RAM_ADDRESS];
    always @(posedge CLK) if (RAM_MEM_WRITE) dmem[RAM_ADDRESS] <= RAM_WRITE_DATA;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    function automatic logic m_err(input logic w, input logic [2:0] f, input logic [1:0] a);
        int  size;
        logic legal;
        size  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || (int'(a) % size != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] w, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = w[16*a[1] +: 16];
        case (f)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Transaction model: a request finishes a fixed number of edges after acceptance
    logic [31:0] ref_mem [1024] = '{default: 32'h0};
    logic        armed = 1'b0;
    logic        m_ready = 1'b0;
    logic        pend = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_load = 32'h0;
    logic        p_w = 1'b0;
    logic [2:0]  p_f3 = 3'b0;
    logic [31:0] p_addr = 32'h0;
    logic [31:0] p_wd = 32'h0;
    int          edge_n = 0;
    int          done_e = 0;

    always @(posedge CLK) begin
        if (!RST_N) begin
            armed     <= 1'b1;
            m_ready   <= 1'b1;
            pend      <= 1'b0;
            exp_valid <= 1'b0;
            exp_err   <= 1'b0;
            exp_load  <= 32'h0;
        end else if (pend && edge_n == done_e) begin
            if (p_w) begin
                case (p_f3)
                    3'd0:    ref_mem[p_addr[11:2]][8*p_addr[1:0] +: 8] <= p_wd[7:0];
                    3'd1:    ref_mem[p_addr[11:2]][16*p_addr[1] +: 16] <= p_wd[15:0];
                    default: ref_mem[p_addr[11:2]] <= p_wd;
                endcase
            end else begin
                exp_load <= m_load(p_f3, ref_mem[p_addr[11:2]], p_addr[1:0]);
            end
            pend      <= 1'b0;
            m_ready   <= 1'b1;
            exp_valid <= 1'b1;
            exp_err   <= 1'b0;
        end else begin
            exp_valid <= 1'b0;
            exp_err   <= 1'b0;
            if (m_ready && REQ_VALID) begin
                if (m_err(REQ_WRITE, REQ_FUNCT3, REQ_ADDR[1:0])) begin
                    exp_valid <= 1'b1;
                    exp_err   <= 1'b1;
                end else begin
                    pend    <= 1'b1;
                    m_ready <= 1'b0;
                    p_w     <= REQ_WRITE;
                    p_f3    <= REQ_FUNCT3;
                    p_addr  <= REQ_ADDR;
                    p_wd    <= REQ_WDATA;
                    done_e  <= edge_n + ((REQ_WRITE && REQ_FUNCT3 != 3'd2) ? 2 : 1);
                end
            end
        end
        edge_n <= edge_n + 1;
    end

    always @(negedge CLK) begin
        if (armed) begin
            chk("req_ready", {31'h0, REQ_READY}, {31'h0, m_ready});
            chk("resp_valid", {31'h0, RESP_VALID}, {31'h0, exp_valid});
            chk("resp_err", {31'h0, RESP_ERR}, {31'h0, exp_err});
            chk("load_data", LOAD_DATA, exp_load);
        end
    end

    // Issues one request and measures its latency in cycles from the accept edge
    task automatic txn(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                       input int exp_lat, input logic exp_e, input logic [31:0] exp_ld, input string nm);
        int n;
        int lat;
        REQ_VALID  = 1'b1;
        REQ_WRITE  = w;
        REQ_FUNCT3 = f;
        REQ_ADDR   = a;
        REQ_WDATA  = wd;
        n = 0;
        while (!REQ_READY && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({nm, " accept"}, {31'h0, REQ_READY}, 32'h1);
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        lat = 1;
        while (!RESP_VALID && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " err"}, {31'h0, RESP_ERR}, {31'h0, exp_e});
        if (exp_e) chk({nm, " ready"}, {31'h0, REQ_READY}, 32'h1);
        if (!w && !exp_e) chk({nm, " data"}, LOAD_DATA, exp_ld);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        int acc;
        int bad;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset resp_valid", {31'h0, RESP_VALID}, 32'h0);
        chk("reset load_data", LOAD_DATA, 32'h0);
        chk("reset ram_we", {31'h0, RAM_MEM_WRITE}, 32'h0);
        RST_N = 1'b1;
        chk("reset ready", {31'h0, REQ_READY}, 32'h1);
        txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0, "sw");
        chk("ram4 after sw", dmem[4], 32'hDEADBEEF);
        txn(1'b0, 3'd0, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFFDE, "lb");
        txn(1'b0, 3'd4, 32'h13, 32'h0, 2, 1'b0, 32'h000000DE, "lbu");
        txn(1'b0, 3'd1, 32'h10, 32'h0, 2, 1'b0, 32'hFFFFBEEF, "lh");
        txn(1'b0, 3'd5, 32'h12, 32'h0, 2, 1'b0, 32'h0000DEAD, "lhu");
        txn(1'b1, 3'd0, 32'h11, 32'hFFFFFF55, 3, 1'b0, 32'h0, "sb");
        chk("ram4 after sb", dmem[4], 32'hDEAD55EF);
        txn(1'b1, 3'd1, 32'h12, 32'hABCD1234, 3, 1'b0, 32'h0, "sh");
        chk("ram4 after sh", dmem[4], 32'h123455EF);
        txn(1'b0, 3'd2, 32'h06, 32'h0, 1, 1'b1, 32'h0, "lw misaligned");
        txn(1'b1, 3'd1, 32'h01, 32'h77777777, 1, 1'b1, 32'h0, "sh misaligned");
        txn(1'b0, 3'd3, 32'h10, 32'h0, 1, 1'b1, 32'h0, "load f3=011");
        txn(1'b1, 3'd4, 32'h10, 32'h0, 1, 1'b1, 32'h0, "store f3=100");
        chk("ram0 after errors", dmem[0], 32'h0);
        chk("ram1 after errors", dmem[1], 32'h0);
        chk("ram4 after errors", dmem[4], 32'h123455EF);
        // SB abandoned by reset while the merged word is waiting to be written
        REQ_VALID  = 1'b1;
        REQ_WRITE  = 1'b1;
        REQ_FUNCT3 = 3'd0;
        REQ_ADDR   = 32'h10;
        REQ_WDATA  = 32'hAA;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        chk("abort resp_valid", {31'h0, RESP_VALID}, 32'h0);
        chk("abort ram4", dmem[4], 32'h123455EF);
        chk("abort ready", {31'h0, REQ_READY}, 32'h1);
        RST_N = 1'b1;
        // Continuous requests alternating SW (aliased address) and LW
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            logic a;
            REQ_VALID  = 1'b1;
            REQ_WRITE  = (acc % 2) == 0;
            REQ_FUNCT3 = 3'd2;
            REQ_ADDR   = (acc % 2) == 0 ? 32'h1010 : 32'h10;
            REQ_WDATA  = 32'hCAFEF00D;
            a = REQ_READY;
            @(posedge CLK); #1;
            if (a) acc++;
        end
        REQ_VALID = 1'b0;
        chk("b2b accepts", acc, 10);
        repeat (3) @(posedge CLK);
        #1;
        chk("alias ram4", dmem[4], 32'hCAFEF00D);
        chk("alias load", LOAD_DATA, 32'hCAFEF00D);
        txn(1'b0, 3'd2, 32'hFFFF_F010, 32'h0, 2, 1'b0, 32'hCAFEF00D, "lw wrapped");
        repeat (400) begin
            REQ_VALID  = $urandom_range(0, 2) != 0;
            REQ_WRITE  = 1'($urandom_range(0, 1));
            REQ_FUNCT3 = $urandom_range(0, 3) == 0 ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
            REQ_ADDR   = (($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFFF000) : 32'h0) | 32'($urandom_range(0, 63));
            REQ_WDATA  = $urandom;
            @(posedge CLK); #1;
        end
        REQ_VALID = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        bad = 0;
        for (int i = 0; i < 1024; i++) if (dmem[i] !== ref_mem[i]) bad++;
        chk("ram image mismatching words", bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
